// File: rtl/word_serializer.sv
// ----------------------------------------------------------------------------
// word_serializer
//
// Accepts one WORD_WIDTH-bit word per valid/ready handshake. It emits the word
// as NBYTES symbols of BYTE_WIDTH bits over a valid/ready byte stream. The
// order is MSB-first or LSB-first, chosen by MSB_FIRST. The block keeps a
// 16-bit wrapping count of fully emitted words.
//
// Ports:
//   clk         single clock, all state changes on posedge
//   reset       asynchronous, active-high; clears all state immediately
//   in_valid    upstream word valid
//   in_ready    block can accept a word (combinational, IDLE only)
//   in_data     word to serialize, sampled on in_valid && in_ready
//   out_valid   out_data holds a valid byte (registered)
//   out_ready   downstream accepts the byte
//   out_data    current byte (registered, held while out_valid is low)
//   out_last    high with the final byte of a word (registered)
//   busy        a word is in flight (state != IDLE)
//   word_count  number of completed words, wraps 0xFFFF -> 0x0000
//
// WORD_WIDTH must be an integer multiple of BYTE_WIDTH.
// ----------------------------------------------------------------------------
module word_serializer #(
    parameter int WORD_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BYTE_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic [15:0]           word_count
);

    localparam int NBYTES = WORD_WIDTH / BYTE_WIDTH;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [7:0] {
        IDLE = 8'd0,
        SEND = 8'd1
    } state_t;

    state_t                fsm_state;
    state_t                state_nxt;
    logic [WORD_WIDTH-1:0] shift_reg;
    logic [WORD_WIDTH-1:0] shift_nxt;
    logic [WORD_WIDTH-1:0] shifted;
    logic [IDX_W-1:0]      byte_idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic [IDX_W-1:0]      idx_inc;
    logic                  out_valid_nxt;
    logic                  out_last_nxt;
    logic [BYTE_WIDTH-1:0] out_data_nxt;
    logic                  count_inc;

    // The byte to emit always sits at the "emitted end" of the shift register,
    // so both the first byte and every later byte come from the same slice.
    function automatic logic [BYTE_WIDTH-1:0] head_byte(input logic [WORD_WIDTH-1:0] w);
        if (MSB_FIRST != 0)
            return w[WORD_WIDTH-1 -: BYTE_WIDTH];
        else
            return w[BYTE_WIDTH-1:0];
    endfunction

    assign in_ready = (fsm_state == IDLE);
    assign busy     = (fsm_state != IDLE);

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_nxt     = fsm_state;
        shift_nxt     = shift_reg;
        idx_nxt       = byte_idx;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_last_nxt  = out_last;
        count_inc     = 1'b0;
        shifted       = (MSB_FIRST != 0) ? (shift_reg << BYTE_WIDTH)
                                         : (shift_reg >> BYTE_WIDTH);
        idx_inc       = byte_idx + 1'b1;

        case (fsm_state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shift_nxt     = in_data;
                    idx_nxt       = '0;
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = head_byte(in_data);
                    out_last_nxt  = (NBYTES == 1);
                    state_nxt     = SEND;
                end
            end
            SEND: begin
                // out_valid is always high in SEND, so out_ready alone marks
                // the handshake; outputs hold otherwise (no retraction).
                if (out_ready) begin
                    if (byte_idx == LAST_IDX) begin
                        out_valid_nxt = 1'b0;
                        out_last_nxt  = 1'b0;
                        count_inc     = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        shift_nxt     = shifted;
                        idx_nxt       = idx_inc;
                        out_data_nxt  = head_byte(shifted);
                        out_last_nxt  = (idx_inc == LAST_IDX);
                    end
                end
            end
            default: begin
                state_nxt     = IDLE;
                out_valid_nxt = 1'b0;
                out_last_nxt  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments let all registers update together
        // from the values sampled at the same edge.
        if (reset) begin
            fsm_state <= IDLE;
            shift_reg <= '0;
            byte_idx  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            fsm_state <= state_nxt;
            shift_reg <= shift_nxt;
            byte_idx  <= idx_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_last  <= out_last_nxt;
        end
    end

    // Completed-word counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            word_count <= '0;
        else if (count_inc)
            word_count <= word_count + 16'd1;
    end

endmodule

// File: tb/tb_word_serializer.sv
// ----------------------------------------------------------------------------
// tb_word_serializer
//
// Self-checking bench for word_serializer. It uses an MSB-first instance and
// an LSB-first instance. A per-cycle vector table covers reset, basic
// serialization and backpressure. Hand-written sequences cover back-to-back
// words, LSB order, reset in the middle of a word and counter wrap.
// ----------------------------------------------------------------------------
module tb_word_serializer;

    logic        clk;
    logic        reset;

    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_last, d_busy;
    logic [31:0] d_in_data;
    logic [7:0]  d_out_data;
    logic [15:0] d_word_count;

    logic        l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_out_last, l_busy;
    logic [31:0] l_in_data;
    logic [7:0]  l_out_data;
    logic [15:0] l_word_count;

    int n_cmp  = 0;
    int n_fail = 0;

    word_serializer #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
        .out_last(d_out_last), .busy(d_busy), .word_count(d_word_count)
    );

    word_serializer #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset),
        .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .out_data(l_out_data),
        .out_last(l_out_last), .busy(l_busy), .word_count(l_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: inputs driven before the call are sampled at this posedge,
    // outputs are read 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one word into the MSB-first instance with out_ready high and
    // checks each byte against the word, most-significant first.
    task automatic serialize_msb(input string tag, input logic [31:0] w);
        logic [7:0] exp_b;
        d_in_valid  = 1'b1;
        d_in_data   = w;
        d_out_ready = 1'b1;
        tick();
        d_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_b = w[31 - 8*i -: 8];
            check($sformatf("%s valid[%0d]", tag, i), 32'(d_out_valid), 32'd1);
            check($sformatf("%s byte[%0d]", tag, i), 32'(d_out_data), 32'(exp_b));
            check($sformatf("%s last[%0d]", tag, i), 32'(d_out_last), 32'(i == 3));
            tick();
        end
        check({tag, " done valid"}, 32'(d_out_valid), 32'd0);
        check({tag, " done in_ready"}, 32'(d_in_ready), 32'd1);
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        ov;
        logic [7:0]  dout;
        logic        last;
        logic        irdy;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // ---------------- vector table (MSB-first instance) -----------------
        //              iv    din           ordy  | ov    dout   last  irdy  cnt
        // Basic: 0x0000007B, out_ready held high.
        vecs[0]  = '{1'b1, 32'h0000007B, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h7B, 1'b1, 1'b0, 16'd0};
        vecs[4]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 8'h7B, 1'b0, 1'b1, 16'd1};
        // Backpressure: 0xDEADBEEF, out_ready 1,0,0,1,0,1,1 once the first byte is
        // visible. in_valid is raised with other data while busy and must be ignored.
        vecs[5]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 8'hDE, 1'b0, 1'b0, 16'd1};
        vecs[6]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'hAD, 1'b0, 1'b0, 16'd1};
        vecs[7]  = '{1'b1, 32'h12345678, 1'b0, 1'b1, 8'hAD, 1'b0, 1'b0, 16'd1};
        vecs[8]  = '{1'b1, 32'h12345678, 1'b0, 1'b1, 8'hAD, 1'b0, 1'b0, 16'd1};
        vecs[9]  = '{1'b1, 32'h12345678, 1'b1, 1'b1, 8'hBE, 1'b0, 1'b0, 16'd1};
        vecs[10] = '{1'b1, 32'h12345678, 1'b0, 1'b1, 8'hBE, 1'b0, 1'b0, 16'd1};
        vecs[11] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'hEF, 1'b1, 1'b0, 16'd1};
        vecs[12] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 8'hEF, 1'b0, 1'b1, 16'd2};

        d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b0;
        l_in_valid = 1'b0; l_in_data = '0; l_out_ready = 1'b0;

        // ---------------- reset ----------------
        reset = 1'b1;
        #2;
        check("reset out_valid", 32'(d_out_valid), 32'd0);
        check("reset out_data", 32'(d_out_data), 32'd0);
        check("reset out_last", 32'(d_out_last), 32'd0);
        check("reset busy", 32'(d_busy), 32'd0);
        check("reset word_count", 32'(d_word_count), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #2;
        check("post-reset in_ready", 32'(d_in_ready), 32'd1);
        check("post-reset lsb in_ready", 32'(l_in_ready), 32'd1);

        // ---------------- table ----------------
        for (int i = 0; i < 13; i++) begin
            d_in_valid  = vecs[i].iv;
            d_in_data   = vecs[i].din;
            d_out_ready = vecs[i].ordy;
            tick();
            check($sformatf("vec%0d out_valid", i), 32'(d_out_valid), 32'(vecs[i].ov));
            check($sformatf("vec%0d out_data", i), 32'(d_out_data), 32'(vecs[i].dout));
            check($sformatf("vec%0d out_last", i), 32'(d_out_last), 32'(vecs[i].last));
            check($sformatf("vec%0d in_ready", i), 32'(d_in_ready), 32'(vecs[i].irdy));
            check($sformatf("vec%0d busy", i), 32'(d_busy), 32'(!vecs[i].irdy));
            check($sformatf("vec%0d word_count", i), 32'(d_word_count), 32'(vecs[i].cnt));
        end

        // ---------------- back-to-back ----------------
        begin
            logic [31:0] words [2];
            logic [7:0]  exp_b2b [8];
            logic [7:0]  got [$];
            int          acc_cycle [$];
            int          widx;
            words   = '{32'hA1A2A3A4, 32'hB1B2B3B4};
            exp_b2b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
            widx = 0;
            d_in_valid  = 1'b1;
            d_in_data   = words[0];
            d_out_ready = 1'b1;
            for (int c = 1; c <= 10; c++) begin
                logic acc;
                acc = d_in_valid && d_in_ready;
                if (d_out_valid && d_out_ready) got.push_back(d_out_data);
                tick();
                if (acc) begin
                    acc_cycle.push_back(c);
                    widx++;
                    // The upstream moves on to the next word right away; the
                    // word still being serialized must not change.
                    if (widx < 2) d_in_data = words[widx];
                    else begin
                        d_in_valid = 1'b0;
                        d_in_data  = 32'hFFFF_FFFF;
                    end
                end
                if (c == 5) begin
                    check("b2b bubble in_ready", 32'(d_in_ready), 32'd1);
                    check("b2b bubble out_valid", 32'(d_out_valid), 32'd0);
                end
            end
            check("b2b byte count", 32'(got.size()), 32'd8);
            for (int i = 0; i < 8; i++) begin
                if (i < got.size())
                    check($sformatf("b2b byte[%0d]", i), 32'(got[i]), 32'(exp_b2b[i]));
                else
                    check($sformatf("b2b byte[%0d] missing", i), 32'd0, 32'(exp_b2b[i]));
            end
            check("b2b accepts", 32'(acc_cycle.size()), 32'd2);
            if (acc_cycle.size() == 2) begin
                check("b2b first accept cycle", 32'(acc_cycle[0]), 32'd1);
                check("b2b second accept cycle", 32'(acc_cycle[1]), 32'd6);
            end
            check("b2b word_count", 32'(d_word_count), 32'd4);
            check("b2b idle in_ready", 32'(d_in_ready), 32'd1);
        end

        // ---------------- LSB-first instance ----------------
        begin
            logic [7:0] exp_lsb [4];
            exp_lsb = '{8'h44, 8'h33, 8'h22, 8'h11};
            l_in_valid  = 1'b1;
            l_in_data   = 32'h11223344;
            l_out_ready = 1'b1;
            tick();
            l_in_valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                check($sformatf("lsb valid[%0d]", i), 32'(l_out_valid), 32'd1);
                check($sformatf("lsb byte[%0d]", i), 32'(l_out_data), 32'(exp_lsb[i]));
                check($sformatf("lsb last[%0d]", i), 32'(l_out_last), 32'(i == 3));
                tick();
            end
            check("lsb done valid", 32'(l_out_valid), 32'd0);
            check("lsb word_count", 32'(l_word_count), 32'd1);
        end

        // ---------------- reset mid-word ----------------
        d_in_valid  = 1'b1;
        d_in_data   = 32'h01020304;
        d_out_ready = 1'b1;
        tick();
        d_in_valid = 1'b0;
        check("midrst byte0", 32'(d_out_data), 32'h01);
        tick();
        check("midrst byte1", 32'(d_out_data), 32'h02);
        tick();
        check("midrst byte2", 32'(d_out_data), 32'h03);
        #2;
        reset = 1'b1;
        #1;
        check("midrst async out_valid", 32'(d_out_valid), 32'd0);
        check("midrst async out_last", 32'(d_out_last), 32'd0);
        check("midrst async busy", 32'(d_busy), 32'd0);
        check("midrst word_count", 32'(d_word_count), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("midrst release in_ready", 32'(d_in_ready), 32'd1);
        check("midrst release out_valid", 32'(d_out_valid), 32'd0);
        serialize_msb("after-reset", 32'h05060708);
        check("after-reset word_count", 32'(d_word_count), 32'd1);

        // ---------------- counter wrap ----------------
        force dut_msb.word_count = 16'hFFFF;
        #1;
        release dut_msb.word_count;
        #1;
        check("wrap preload", 32'(d_word_count), 32'h0000FFFF);
        serialize_msb("wrap", 32'hCAFEF00D);
        check("wrap word_count", 32'(d_word_count), 32'h00000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
